// File: rtl/lf_spi_cmd_rx_if.sv
// lf_spi_cmd_rx_if: ARM SPI pins plus decoded configuration outputs of the LF command receiver.
interface lf_spi_cmd_rx_if;
    logic        spck;
    logic        mosi;
    logic        ncs;
    logic        miso;
    logic [11:0] conf_word;
    logic [2:0]  major_mode;
    logic [7:0]  divisor;
    logic [7:0]  lf_ed_threshold;
    logic        cmd_strobe;
    logic [3:0]  cmd_code;
    logic        frame_err;

    modport slave (
        input  spck, mosi, ncs,
        output miso, conf_word, major_mode, divisor, lf_ed_threshold, cmd_strobe, cmd_code, frame_err
    );

    modport master (
        output spck, mosi, ncs,
        input  miso, conf_word, major_mode, divisor, lf_ed_threshold, cmd_strobe, cmd_code, frame_err
    );
endinterface

// File: rtl/lf_spi_cmd_rx.sv
// lf_spi_cmd_rx: oversampled SPI slave that decodes 16-bit ARM command frames into LF configuration registers.
module lf_spi_cmd_rx #(
    parameter int         SYNC_STAGES    = 2,
    parameter logic [7:0] DIVISOR_RST    = 8'd95,
    parameter logic [7:0] THRESH_DEFAULT = 8'd127
) (
    input  logic           pck0,
    input  logic           nreset,
    lf_spi_cmd_rx_if.slave bus
);
    typedef enum logic [1:0] {SKIP, IDLE, RECV, COMMIT} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] spck_sync_q, mosi_sync_q, ncs_sync_q;
    logic                   spck_prev_q, ncs_prev_q;
    logic [15:0]            shift_q, shift_d, rb_q, rb_d;
    logic [4:0]             cnt_q, cnt_d;
    logic [1:0]             skip_q, skip_d;
    logic [11:0]            conf_q, conf_d;
    logic [7:0]             div_q, div_d, thr_q, thr_d;
    logic [3:0]             code_q, code_d;
    logic                   strobe_q, strobe_d, err_q, err_d;
    logic                   spck_s, mosi_s, ncs_s, spck_rise, spck_fall, ncs_rise, ncs_fall, good;
    logic [3:0]             op;

    assign spck_s    = spck_sync_q[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign ncs_s     = ncs_sync_q[SYNC_STAGES-1];
    assign spck_rise = spck_s & ~spck_prev_q;
    assign spck_fall = ~spck_s & spck_prev_q;
    assign ncs_rise  = ncs_s & ~ncs_prev_q;
    assign ncs_fall  = ~ncs_s & ncs_prev_q;
    assign good      = cnt_q == 5'd16;
    assign op        = shift_q[15:12];

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        rb_d     = rb_q;
        cnt_d    = cnt_q;
        skip_d   = 2'd0;
        conf_d   = conf_q;
        div_d    = div_q;
        thr_d    = thr_q;
        code_d   = code_q;
        err_d    = err_q;
        strobe_d = 1'b0;
        case (state_q)
            SKIP: begin
                // Reset-value ones must drain out of the synchroniser before ncs high is trusted
                skip_d  = ncs_s ? skip_q + 2'd1 : 2'd0;
                state_d = (ncs_s && skip_q == 2'(SYNC_STAGES)) ? IDLE : SKIP;
            end
            IDLE: begin
                if (ncs_fall) begin
                    state_d = RECV;
                    cnt_d   = 5'd0;
                    shift_d = 16'd0;
                    rb_d    = {err_q, 3'b000, conf_q};
                end
            end
            RECV: begin
                if (ncs_rise) begin
                    state_d = COMMIT;
                end else begin
                    shift_d = spck_rise ? {shift_q[14:0], mosi_s} : shift_q;
                    cnt_d   = spck_rise ? (cnt_q == 5'd17 ? 5'd17 : cnt_q + 5'd1) : cnt_q;
                    rb_d    = spck_fall ? {rb_q[14:0], 1'b0} : rb_q;
                end
            end
            COMMIT: begin
                state_d  = IDLE;
                strobe_d = good;
                err_d    = ~good;
                code_d   = good ? op : code_q;
                conf_d   = (good && op == 4'd1) ? shift_q[11:0] : conf_q;
                div_d    = (good && op == 4'd2) ? shift_q[7:0] : div_q;
                thr_d    = (good && op == 4'd3) ? shift_q[7:0] :
                           (good && op == 4'd1 && shift_q[8:6] == 3'b001) ? THRESH_DEFAULT : thr_q;
            end
        endcase
    end

    always_ff @(posedge pck0) begin
        if (!nreset) begin
            state_q     <= SKIP;
            spck_sync_q <= '0;
            mosi_sync_q <= '0;
            ncs_sync_q  <= '1;
            spck_prev_q <= 1'b0;
            ncs_prev_q  <= 1'b1;
            shift_q     <= 16'd0;
            rb_q        <= 16'd0;
            cnt_q       <= 5'd0;
            skip_q      <= 2'd0;
            conf_q      <= 12'd0;
            div_q       <= DIVISOR_RST;
            thr_q       <= THRESH_DEFAULT;
            code_q      <= 4'd0;
            strobe_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            spck_sync_q <= {spck_sync_q[SYNC_STAGES-2:0], bus.spck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
            ncs_sync_q  <= {ncs_sync_q[SYNC_STAGES-2:0], bus.ncs};
            spck_prev_q <= spck_s;
            ncs_prev_q  <= ncs_s;
            shift_q     <= shift_d;
            rb_q        <= rb_d;
            cnt_q       <= cnt_d;
            skip_q      <= skip_d;
            conf_q      <= conf_d;
            div_q       <= div_d;
            thr_q       <= thr_d;
            code_q      <= code_d;
            strobe_q    <= strobe_d;
            err_q       <= err_d;
        end
    end

    assign bus.miso            = (state_q == RECV) & rb_q[15];
    assign bus.conf_word       = conf_q;
    assign bus.major_mode      = conf_q[8:6];
    assign bus.divisor         = div_q;
    assign bus.lf_ed_threshold = thr_q;
    assign bus.cmd_strobe      = strobe_q;
    assign bus.cmd_code        = code_q;
    assign bus.frame_err       = err_q;
endmodule

// File: tb/tb_lf_spi_cmd_rx.sv
// tb_lf_spi_cmd_rx: directed SPI frames against a register model, expectations queued per frame.
module tb_lf_spi_cmd_rx;
    typedef struct {
        logic [15:0] rb;
        int          nbits;
        logic        strobe;
        logic [3:0]  code;
        logic [11:0] conf;
        logic [7:0]  div;
        logic [7:0]  thr;
        logic        err;
    } exp_t;

    localparam int H = 8;

    logic pck0 = 1'b0;
    logic nreset = 1'b0;
    lf_spi_cmd_rx_if bus();

    lf_spi_cmd_rx #(.SYNC_STAGES(2), .DIVISOR_RST(8'd95), .THRESH_DEFAULT(8'd127)) dut (
        .pck0(pck0),
        .nreset(nreset),
        .bus(bus)
    );

    always #5 pck0 = ~pck0;

    int checks = 0, errors = 0;
    int cyc = 0, strobe_total = 0, last_strobe_cyc = 0;
    exp_t sb[$];
    logic [11:0] m_conf;
    logic [7:0]  m_div, m_thr;
    logic [3:0]  m_code;
    logic        m_err;

    always @(posedge pck0) cyc++;
    always @(negedge pck0) if (bus.cmd_strobe) begin strobe_total++; last_strobe_cyc = cyc; end

    task automatic tick(input int n);
        repeat (n) @(negedge pck0);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_conf = 12'd0; m_div = 8'd95; m_thr = 8'd127; m_code = 4'd0; m_err = 1'b0;
    endtask

    task automatic model_frame(input logic [15:0] data, input int nbits);
        exp_t e;
        e.nbits = nbits;
        e.rb = {m_err, 3'b000, m_conf};
        if (nbits == 16) begin
            m_err = 1'b0;
            m_code = data[15:12];
            if (data[15:12] == 4'd1) begin
                m_conf = data[11:0];
                if (data[8:6] == 3'b001) m_thr = 8'd127;
            end else if (data[15:12] == 4'd2) m_div = data[7:0];
            else if (data[15:12] == 4'd3) m_thr = data[7:0];
        end else m_err = 1'b1;
        e.strobe = (nbits == 16);
        e.code = m_code; e.conf = m_conf; e.div = m_div; e.thr = m_thr; e.err = m_err;
        sb.push_back(e);
    endtask

    task automatic send_bits(input logic [15:0] data, input int from, input int to, inout logic [31:0] rd);
        for (int i = from; i < to; i++) begin
            bus.mosi = (i < 16) ? data[15-i] : 1'b1;
            tick(H);
            rd = {rd[30:0], bus.miso};
            bus.spck = 1'b1;
            tick(H);
            bus.spck = 1'b0;
        end
    endtask

    task automatic check_regs(input string tag, input exp_t e);
        check({tag, ".code"}, 32'(bus.cmd_code), 32'(e.code));
        check({tag, ".conf"}, 32'(bus.conf_word), 32'(e.conf));
        check({tag, ".major"}, 32'(bus.major_mode), 32'(e.conf[8:6]));
        check({tag, ".div"}, 32'(bus.divisor), 32'(e.div));
        check({tag, ".thr"}, 32'(bus.lf_ed_threshold), 32'(e.thr));
        check({tag, ".err"}, 32'(bus.frame_err), 32'(e.err));
        check({tag, ".miso_idle"}, 32'(bus.miso), 32'd0);
    endtask

    task automatic verify(input string tag, input logic [31:0] rd, input int s0, input int c0);
        exp_t e;
        logic [31:0] rbx, mask;
        e = sb.pop_front();
        rbx = (e.nbits <= 16) ? (32'(e.rb) >> (16 - e.nbits)) : (32'(e.rb) << (e.nbits - 16));
        mask = (32'd1 << e.nbits) - 32'd1;
        check({tag, ".readback"}, rd & mask, rbx);
        check({tag, ".strobes"}, 32'(strobe_total - s0), e.strobe ? 32'd1 : 32'd0);
        if (e.strobe)
            check({tag, ".latency_ok"}, 32'(last_strobe_cyc - c0 >= 3 && last_strobe_cyc - c0 <= 5), 32'd1);
        check_regs(tag, e);
    endtask

    task automatic frame(input string tag, input logic [15:0] data, input int nbits);
        logic [31:0] rd;
        int s0, c0;
        rd = 32'd0;
        model_frame(data, nbits);
        s0 = strobe_total;
        bus.ncs = 1'b0;
        tick(6);
        send_bits(data, 0, nbits, rd);
        tick(H);
        bus.ncs = 1'b1;
        c0 = cyc;
        tick(12);
        verify(tag, rd, s0, c0);
    endtask

    initial begin
        exp_t r;
        logic [31:0] rd;
        int s0;
        bus.spck = 1'b0; bus.mosi = 1'b0; bus.ncs = 1'b1;
        model_reset();
        tick(4);
        r.code = m_code; r.conf = m_conf; r.div = m_div; r.thr = m_thr; r.err = m_err;
        check("reset.strobe", 32'(bus.cmd_strobe), 32'd0);
        check_regs("reset", r);
        nreset = 1'b1;
        tick(8);

        frame("set_div50", 16'h2050, 16);
        frame("set_thr40", 16'h3040, 16);
        frame("conf041", 16'h1041, 16);
        frame("conf000", 16'h1000, 16);
        frame("short15", 16'h2011, 15);
        frame("long17", 16'h2022, 17);
        frame("set_divFF", 16'h20FF, 16);
        frame("conf0C3", 16'h10C3, 16);
        frame("unknown5", 16'h5123, 16);

        rd = 32'd0;
        s0 = strobe_total;
        bus.ncs = 1'b0;
        tick(6);
        send_bits(16'h20AA, 0, 8, rd);
        nreset = 1'b0;
        tick(3);
        model_reset();
        nreset = 1'b1;
        rd = 32'd0;
        send_bits(16'h20AA, 8, 16, rd);
        tick(H);
        bus.ncs = 1'b1;
        tick(12);
        r.code = m_code; r.conf = m_conf; r.div = m_div; r.thr = m_thr; r.err = m_err;
        check("midrst.strobes", 32'(strobe_total - s0), 32'd0);
        check("midrst.tail_miso", rd & 32'hFF, 32'd0);
        check_regs("midrst", r);

        frame("clean_AA", 16'h20AA, 16);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
